// File: rtl/dmm_adc_pkg.sv
// Shared types and codes for the integrating charge-balance ADC controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, reference-mux codes, nominal clock frequency.
package dmm_adc_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INT_RESET = 3'd1,
        RUNUP     = 3'd2,
        RUNDOWN   = 3'd3,
        DONE      = 3'd4
    } adc_state_t;

    localparam logic [1:0] REF_NONE = 2'd0;
    localparam logic [1:0] REF_POS  = 2'd1;
    localparam logic [1:0] REF_NEG  = 2'd2;

    // Nominal core clock; CYCLE_N = 20 gives a 1 us run-up cycle at this rate.
    localparam int CLK_FREQ = 20000000;

    // Reference that drives the integrator back toward zero for a given comparator sign.
    function automatic logic [1:0] ref_for(input logic integrator_pos);
        return integrator_pos ? REF_NEG : REF_POS;
    endfunction

endpackage

// File: rtl/adc_phase_counter.sv
// Loadable saturating down-counter with a terminal-count pulse.
// Latency: load takes effect on the next clock; tc is combinational from the count.
// Backpressure: none; en simply freezes the count when low.
// Ports: load/load_val (load has priority), en (decrement), tc = en while count is zero.
module adc_phase_counter #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = en && (cnt == '0);

endmodule

// File: rtl/adc_charge_balance.sv
// Integrating charge-balance ADC controller: integrator reset, multislope run-up, single-slope rundown.
// Latency: valid rises 4 clocks after the raw comparator crosses in rundown (2 sync + DONE + latch).
// Backpressure: none; results are held as a level until the next trig, which always restarts a conversion.
// Ports: adc_measure_trig/clk_count_aperture_n start a conversion; comparator is asynchronous;
//        sw_int_reset/refmux drive the analogue switches; count_*/rundown_dir are latched results;
//        monitor = {rundown active, run-up active}.
// Build option: ADC_RUNDOWN_TIMEOUT_EN adds a rundown timeout and the overload output.
module adc_charge_balance
    import dmm_adc_pkg::*;
#(
    parameter int CYCLE_N       = 20,
    parameter int INT_RESET_N   = 100,
`ifdef ADC_RUNDOWN_TIMEOUT_EN
    parameter int RUNDOWN_MAX_N = 4000,
`endif
    parameter int CW            = 24
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          adc_measure_trig,
    input  logic [CW-1:0] clk_count_aperture_n,
    input  logic          comparator,
    output logic          adc_measure_valid,
    output logic          sw_int_reset,
    output logic [1:0]    refmux,
    output logic [CW-1:0] count_up,
    output logic [CW-1:0] count_down,
    output logic [CW-1:0] count_rundown,
    output logic          rundown_dir,
`ifdef ADC_RUNDOWN_TIMEOUT_EN
    output logic          overload,
`endif
    output logic [1:0]    monitor
);

`ifdef ADC_RUNDOWN_TIMEOUT_EN
    localparam logic [CW-1:0] RD_LIMIT = CW'(RUNDOWN_MAX_N);
`endif

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    // Reset asserts asynchronously, releases two clocks after reset_n rises.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // Comparator is asynchronous to clk; every decision uses comp_s.
    logic [1:0] comp_sync;
    logic       comp_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comp_sync <= 2'b00;
        end else begin
            comp_sync <= {comp_sync[0], comparator};
        end
    end

    assign comp_s = comp_sync[1];

    adc_state_t    state;
    logic [CW-1:0] up_w;
    logic [CW-1:0] dn_w;
    logic [CW-1:0] rd_w;
    logic          dir_w;
`ifdef ADC_RUNDOWN_TIMEOUT_EN
    logic          ovl_w;
`endif

    logic          ir_tc;
    logic          cyc_tc;
    logic          ap_tc;
    logic          cyc_load;
    logic [CW-1:0] cyc_val;
    logic [CW-1:0] ap_val;

    // Integrator short: loaded on trig, counts out INT_RESET_N clocks of INT_RESET.
    adc_phase_counter #(.W(CW)) u_ir_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (adc_measure_trig),
        .load_val (CW'(INT_RESET_N - 1)),
        .en       (state == INT_RESET),
        .tc       (ir_tc)
    );

    // Run-up cycle timer: loaded with 0 on RUNUP entry so the first clock is a boundary,
    // then reloaded at every boundary to mark the next one CYCLE_N clocks later.
    assign cyc_load = adc_measure_trig || ir_tc || cyc_tc;
    assign cyc_val  = cyc_tc ? CW'(CYCLE_N - 1) : '0;

    adc_phase_counter #(.W(CW)) u_cyc_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cyc_load),
        .load_val (cyc_val),
        .en       (state == RUNUP),
        .tc       (cyc_tc)
    );

    // Aperture timer: a zero aperture is loaded as 1 so run-up always performs one cycle.
    assign ap_val = (clk_count_aperture_n == '0) ? CW'(1) : clk_count_aperture_n;

    adc_phase_counter #(.W(CW)) u_ap_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (adc_measure_trig),
        .load_val (ap_val),
        .en       (state == RUNUP),
        .tc       (ap_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            adc_measure_valid <= 1'b0;
            sw_int_reset      <= 1'b1;
            refmux            <= REF_NONE;
            count_up          <= '0;
            count_down        <= '0;
            count_rundown     <= '0;
            rundown_dir       <= 1'b0;
            up_w              <= '0;
            dn_w              <= '0;
            rd_w              <= '0;
            dir_w             <= 1'b0;
`ifdef ADC_RUNDOWN_TIMEOUT_EN
            overload          <= 1'b0;
            ovl_w             <= 1'b0;
`endif
        end else if (adc_measure_trig) begin
            // A trig restarts from any state, including DONE, so a half-finished
            // conversion is never latched and the old valid drops immediately.
            state             <= INT_RESET;
            adc_measure_valid <= 1'b0;
            sw_int_reset      <= 1'b1;
            refmux            <= REF_NONE;
            up_w              <= '0;
            dn_w              <= '0;
            rd_w              <= '0;
            dir_w             <= 1'b0;
`ifdef ADC_RUNDOWN_TIMEOUT_EN
            overload          <= 1'b0;
            ovl_w             <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                end
                INT_RESET: begin
                    if (ir_tc) begin
                        state        <= RUNUP;
                        sw_int_reset <= 1'b0;
                    end
                end
                RUNUP: begin
                    if (cyc_tc) begin
                        if (ap_tc) begin
                            state  <= RUNDOWN;
                            dir_w  <= comp_s;
                            refmux <= ref_for(comp_s);
                            rd_w   <= '0;
                        end else if (comp_s) begin
                            refmux <= REF_NEG;
                            dn_w   <= sat_inc(dn_w);
                        end else begin
                            refmux <= REF_POS;
                            up_w   <= sat_inc(up_w);
                        end
                    end
                end
                RUNDOWN: begin
                    if (comp_s != dir_w) begin
                        state        <= DONE;
                        refmux       <= REF_NONE;
                        sw_int_reset <= 1'b1;
                    end
`ifdef ADC_RUNDOWN_TIMEOUT_EN
                    else if (rd_w == RD_LIMIT) begin
                        state        <= DONE;
                        refmux       <= REF_NONE;
                        sw_int_reset <= 1'b1;
                        ovl_w        <= 1'b1;
                    end
`endif
                    else begin
                        rd_w <= sat_inc(rd_w);
                    end
                end
                DONE: begin
                    count_up          <= up_w;
                    count_down        <= dn_w;
                    count_rundown     <= rd_w;
                    rundown_dir       <= dir_w;
`ifdef ADC_RUNDOWN_TIMEOUT_EN
                    overload          <= ovl_w;
`endif
                    adc_measure_valid <= 1'b1;
                    state             <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign monitor = {state == RUNDOWN, state == RUNUP};

endmodule

// File: tb/tb_adc_charge_balance.sv
// Directed bench for adc_charge_balance with hand-computed timings and counts.
// Latency: n/a.
// Backpressure: n/a.
module tb_adc_charge_balance;

    localparam int CW = 24;

    logic          clk                  = 1'b0;
    logic          reset_n              = 1'b0;
    logic          adc_measure_trig     = 1'b0;
    logic [CW-1:0] clk_count_aperture_n = '0;
    logic          comparator           = 1'b0;
    logic          adc_measure_valid;
    logic          sw_int_reset;
    logic [1:0]    refmux;
    logic [CW-1:0] count_up;
    logic [CW-1:0] count_down;
    logic [CW-1:0] count_rundown;
    logic          rundown_dir;
`ifdef ADC_RUNDOWN_TIMEOUT_EN
    logic          overload;
`endif
    logic [1:0]    monitor;

    int n_cmp = 0;
    int n_err = 0;
    int n     = 0;

    adc_charge_balance dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .adc_measure_trig     (adc_measure_trig),
        .clk_count_aperture_n (clk_count_aperture_n),
        .comparator           (comparator),
        .adc_measure_valid    (adc_measure_valid),
        .sw_int_reset         (sw_int_reset),
        .refmux               (refmux),
        .count_up             (count_up),
        .count_down           (count_down),
        .count_rundown        (count_rundown),
        .rundown_dir          (rundown_dir),
`ifdef ADC_RUNDOWN_TIMEOUT_EN
        .overload             (overload),
`endif
        .monitor              (monitor)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_trig(input int ap);
        clk_count_aperture_n = CW'(ap);
        adc_measure_trig     = 1'b1;
        tick();
        adc_measure_trig     = 1'b0;
    endtask

    task automatic wait_rundown(output int cnt);
        cnt = 0;
        while (monitor[1] !== 1'b1 && cnt < 1000) begin
            tick();
            cnt++;
        end
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (adc_measure_valid !== 1'b1 && cnt < 5000) begin
            tick();
            cnt++;
        end
    endtask

    task automatic chk_result(input string nm, input int up, input int dn, input int rd, input int dir);
        chk({nm, ".count_up"},      32'(count_up),      32'(up));
        chk({nm, ".count_down"},    32'(count_down),    32'(dn));
        chk({nm, ".count_rundown"}, 32'(count_rundown), 32'(rd));
        chk({nm, ".rundown_dir"},   32'(rundown_dir),   32'(dir));
        chk({nm, ".refmux_idle"},   32'(refmux),        32'd0);
        chk({nm, ".sw_idle"},       32'(sw_int_reset),  32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst.valid",   32'(adc_measure_valid), 32'd0);
        chk("rst.sw",      32'(sw_int_reset),      32'd1);
        chk("rst.refmux",  32'(refmux),            32'd0);
        chk("rst.up",      32'(count_up),          32'd0);
        chk("rst.rundown", 32'(count_rundown),     32'd0);
        chk("rst.monitor", 32'(monitor),           32'd0);
`ifdef ADC_RUNDOWN_TIMEOUT_EN
        chk("rst.overload", 32'(overload),         32'd0);
`endif
        reset_n = 1'b1;
        repeat (4) tick();

        // T1: aperture 200, comparator low in run-up, crossing 37 clocks into rundown
        comparator = 1'b0;
        do_trig(200);
        chk("t1.valid_ir", 32'(adc_measure_valid), 32'd0);
        chk("t1.sw_ir",    32'(sw_int_reset),      32'd1);
        wait_rundown(n);
        chk("t1.to_rundown", 32'(n), 32'd301);
        chk("t1.rd_refmux", 32'(refmux), 32'd1);
        repeat (37) tick();
        comparator = 1'b1;
        wait_valid(n);
        chk("t1.valid_lat", 32'(n), 32'd4);
        chk_result("t1", 10, 0, 39, 0);
`ifdef ADC_RUNDOWN_TIMEOUT_EN
        chk("t1.overload", 32'(overload), 32'd0);
`endif

        // T2: aperture 400, comparator alternating per run-up cycle
        comparator = 1'b0;
        do_trig(400);
        for (int t = 1; t <= 501; t++) begin
            tick();
            if (t >= 91 && t <= 491 && (t - 91) % 20 == 0)
                comparator = (((t - 91) / 20) % 2) == 1;
            if (t >= 101 && t <= 481 && (t - 101) % 20 == 0)
                chk("t2.refmux", 32'(refmux), (((t - 101) / 20) % 2 == 1) ? 32'd2 : 32'd1);
            if (t == 99)
                chk("t2.sw_ir_last", 32'(sw_int_reset), 32'd1);
            if (t == 100) begin
                chk("t2.sw_runup",  32'(sw_int_reset), 32'd0);
                chk("t2.mon_runup", 32'(monitor),      32'd1);
            end
        end
        chk("t2.mon_rundown", 32'(monitor), 32'd2);
        chk("t2.rd_refmux",   32'(refmux),  32'd1);
        repeat (5) tick();
        comparator = 1'b1;
        wait_valid(n);
        chk("t2.valid_lat", 32'(n), 32'd4);
        chk_result("t2", 10, 10, 7, 0);

        // T3: zero aperture runs one cycle; comparator high gives -ref rundown
        do_trig(0);
        chk("t3.valid_drop", 32'(adc_measure_valid), 32'd0);
        wait_rundown(n);
        chk("t3.to_rundown", 32'(n), 32'd121);
        chk("t3.rd_refmux",  32'(refmux), 32'd2);
        comparator = 1'b0;
        wait_valid(n);
        chk("t3.valid_lat", 32'(n), 32'd4);
        chk_result("t3", 0, 1, 2, 1);

        // T4: second trig mid run-up restarts the working counters
        do_trig(100);
        repeat (149) tick();
        chk("t4.mon_runup", 32'(monitor), 32'd1);
        comparator = 1'b1;
        do_trig(60);
        chk("t4.valid", 32'(adc_measure_valid), 32'd0);
        chk("t4.mon",   32'(monitor),           32'd0);
        chk("t4.sw",    32'(sw_int_reset),      32'd1);
        wait_rundown(n);
        chk("t4.to_rundown", 32'(n), 32'd161);
        chk("t4.rd_refmux",  32'(refmux), 32'd2);
        repeat (10) tick();
        comparator = 1'b0;
        wait_valid(n);
        chk("t4.valid_lat", 32'(n), 32'd4);
        chk_result("t4", 0, 3, 12, 1);

        // T5: trig landing on the DONE clock wins and nothing is latched
        do_trig(20);
        wait_rundown(n);
        chk("t5.to_rundown", 32'(n), 32'd121);
        chk("t5.rd_refmux",  32'(refmux), 32'd1);
        comparator = 1'b1;
        repeat (3) tick();
        chk("t5.mon_done", 32'(monitor), 32'd0);
        do_trig(20);
        chk("t5.valid",     32'(adc_measure_valid), 32'd0);
        chk("t5.keep_down", 32'(count_down),        32'd3);
        chk("t5.keep_rd",   32'(count_rundown),     32'd12);
        wait_rundown(n);
        chk("t5b.to_rundown", 32'(n), 32'd121);
        chk("t5b.rd_refmux",  32'(refmux), 32'd2);
        repeat (3) tick();
        comparator = 1'b0;
        wait_valid(n);
        chk("t5b.valid_lat", 32'(n), 32'd4);
        chk_result("t5b", 0, 1, 5, 1);

        // T6: asynchronous reset in the middle of rundown
        do_trig(20);
        wait_rundown(n);
        chk("t6.to_rundown", 32'(n), 32'd121);
        chk("t6.sw_rd",      32'(sw_int_reset), 32'd0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6.refmux", 32'(refmux),            32'd0);
        chk("t6.sw",     32'(sw_int_reset),      32'd1);
        chk("t6.mon",    32'(monitor),           32'd0);
        chk("t6.valid",  32'(adc_measure_valid), 32'd0);
        chk("t6.down",   32'(count_down),        32'd0);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();

`ifdef ADC_RUNDOWN_TIMEOUT_EN
        // T7: comparator stuck in rundown hits the timeout
        comparator = 1'b0;
        do_trig(20);
        wait_rundown(n);
        chk("t7.to_rundown", 32'(n), 32'd121);
        wait_valid(n);
        chk("t7.valid_lat", 32'(n), 32'd4002);
        chk("t7.count_rundown", 32'(count_rundown), 32'd4000);
        chk("t7.overload",      32'(overload),      32'd1);
        chk("t7.rundown_dir",   32'(rundown_dir),   32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
